// File: rtl/clock_mode_controller_pkg.sv
// Shared definitions for the alarm-clock mode controller.
//   state_e       : controller state, also the display-mux mode code
//   HrMaxBcd      : last valid hour value (BCD) before wrapping to 00
//   MinMaxBcd     : last valid minute value (BCD) before wrapping to 00
//   AlarmDefault  : alarm time loaded at reset, {hr, min} in BCD
package clock_mode_controller_pkg;

  typedef enum logic [2:0] {
    StRun    = 3'd0,
    StSetHr  = 3'd1,
    StSetMin = 3'd2,
    StAlHr   = 3'd3,
    StAlMin  = 3'd4
  } state_e;

  localparam logic [7:0]  HrMaxBcd     = 8'h23;
  localparam logic [7:0]  MinMaxBcd    = 8'h59;
  localparam logic [15:0] AlarmDefault = 16'h0700;

endpackage

// File: rtl/clock_mode_controller_bcd_wrap_inc.sv
// Two-digit BCD incrementer with a programmable wrap point.
//   value      in  8  current value, {tens, units} BCD
//   max        in  8  last legal value; value == max wraps to 00
//   value_inc  out 8  value + 1 in BCD, or 00 on wrap
module clock_mode_controller_bcd_wrap_inc (
  input  logic [7:0] value,
  input  logic [7:0] max,
  output logic [7:0] value_inc
);

  always_comb begin
    value_inc = 8'h00;
    if (value != max) begin
      if (value[3:0] >= 4'd9) begin
        value_inc = {value[7:4] + 4'd1, 4'd0};
      end else begin
        value_inc = {value[7:4], value[3:0] + 4'd1};
      end
    end
  end

endmodule

// File: rtl/clock_mode_controller.sv
// Mode sequencer for the alarm clock: gates the 1 Hz tick, issues time-set strobes,
// holds the BCD alarm time and rings the buzzer on an alarm match.
//   clk, rst                      clock, asynchronous active-high reset
//   pulse                         1-cycle 1 Hz tick
//   btn_mode, btn_inc, btn_alarm  debounced button levels
//   left/right_hr/min/sec         live BCD time
//   sec_pulse, sec_clr            gated tick and seconds clear to second_counter
//   min_inc, hr_inc               1-cycle increment strobes to the counters
//   al_left/right_hr/min          alarm time, BCD
//   mode                          current state code for the display mux
//   blink, alarm_on, buzzer       display blink, alarm armed, buzzer ringing
module clock_mode_controller
  import clock_mode_controller_pkg::*;
#(
  parameter int unsigned RING_SECS = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_alarm,
  input  logic [3:0] left_hr,
  input  logic [3:0] right_hr,
  input  logic [3:0] left_min,
  input  logic [3:0] right_min,
  input  logic [3:0] left_sec,
  input  logic [3:0] right_sec,
  output logic       sec_pulse,
  output logic       sec_clr,
  output logic       min_inc,
  output logic       hr_inc,
  output logic [3:0] al_left_hr,
  output logic [3:0] al_right_hr,
  output logic [3:0] al_left_min,
  output logic [3:0] al_right_min,
  output logic [2:0] mode,
  output logic       blink,
  output logic       alarm_on,
  output logic       buzzer
);

  state_e      state;
  logic [2:0]  btn_q, btn_qq;  // {alarm, mode, inc}
  logic [2:0]  edges;
  logic [7:0]  al_hr, al_min, al_hr_next, al_min_next;
  logic [7:0]  ring_cnt;
  logic        fired_q;
  logic        time_match, match;
  logic        ev_silence, ev_alarm, ev_mode, ev_inc;

  clock_mode_controller_bcd_wrap_inc u_hr_inc (
    .value     (al_hr),
    .max       (HrMaxBcd),
    .value_inc (al_hr_next)
  );

  clock_mode_controller_bcd_wrap_inc u_min_inc (
    .value     (al_min),
    .max       (MinMaxBcd),
    .value_inc (al_min_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q  <= '0;
      btn_qq <= '0;
    end else begin
      btn_q  <= {btn_alarm, btn_mode, btn_inc};
      btn_qq <= btn_q;
    end
  end

  assign edges = btn_q & ~btn_qq;

  // Any edge while ringing only silences; otherwise one event per cycle by priority.
  assign ev_silence = buzzer & (|edges);
  assign ev_alarm   = ~buzzer & edges[2];
  assign ev_mode    = ~buzzer & ~edges[2] & edges[1];
  assign ev_inc     = ~buzzer & ~edges[2] & ~edges[1] & edges[0];

  assign time_match = ({left_hr, right_hr} == al_hr) && ({left_min, right_min} == al_min) &&
                      ({left_sec, right_sec} == 8'h00);
  // fired_q holds off a second trigger until the matching second has passed.
  assign match = alarm_on & (state == StRun) & time_match & ~pulse & ~fired_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StRun;
      sec_clr  <= 1'b0;
      min_inc  <= 1'b0;
      hr_inc   <= 1'b0;
      al_hr    <= AlarmDefault[15:8];
      al_min   <= AlarmDefault[7:0];
      alarm_on <= 1'b0;
      buzzer   <= 1'b0;
      blink    <= 1'b0;
      ring_cnt <= '0;
      fired_q  <= 1'b0;
    end else begin
      sec_clr <= 1'b0;
      min_inc <= 1'b0;
      hr_inc  <= 1'b0;
      fired_q <= time_match & (fired_q | match);

      if (state == StRun) begin
        blink <= 1'b0;
      end else if (pulse) begin
        blink <= ~blink;
      end

      if (ev_silence) begin
        buzzer   <= 1'b0;
        ring_cnt <= '0;
      end else if (ev_alarm) begin
        alarm_on <= ~alarm_on;
      end else if (ev_mode) begin
        unique case (state)
          StRun: begin
            state   <= StSetHr;
            sec_clr <= 1'b1;
          end
          StSetHr:  state <= StSetMin;
          StSetMin: state <= StAlHr;
          StAlHr:   state <= StAlMin;
          default:  state <= StRun;
        endcase
      end else if (ev_inc) begin
        unique case (state)
          StSetHr:  hr_inc  <= 1'b1;
          StSetMin: min_inc <= 1'b1;
          StAlHr:   al_hr   <= al_hr_next;
          StAlMin:  al_min  <= al_min_next;
          default:  ;
        endcase
      end

      if (match) begin
        buzzer   <= 1'b1;
        ring_cnt <= RING_SECS[7:0];
      end else if (buzzer && pulse && !ev_silence) begin
        ring_cnt <= ring_cnt - 8'd1;
        if (ring_cnt <= 8'd1) buzzer <= 1'b0;
      end
    end
  end

  // Time keeps running in RUN and while the alarm is edited; frozen while setting time.
  assign sec_pulse    = pulse & (state != StSetHr) & (state != StSetMin);
  assign mode         = state;
  assign al_left_hr   = al_hr[7:4];
  assign al_right_hr  = al_hr[3:0];
  assign al_left_min  = al_min[7:4];
  assign al_right_min = al_min[3:0];

endmodule

// File: tb/tb_clock_mode_controller.sv
// Directed self-checking bench for clock_mode_controller (RING_SECS = 3).
module tb_clock_mode_controller;

  logic       clk, rst, pulse, btn_mode, btn_inc, btn_alarm;
  logic [3:0] left_hr, right_hr, left_min, right_min, left_sec, right_sec;
  logic       sec_pulse, sec_clr, min_inc, hr_inc;
  logic [3:0] al_left_hr, al_right_hr, al_left_min, al_right_min;
  logic [2:0] mode;
  logic       blink, alarm_on, buzzer;

  int checks = 0;
  int failures = 0;
  int cnt_sec_pulse, cnt_sec_clr, cnt_hr_inc, cnt_min_inc;

  clock_mode_controller #(.RING_SECS(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .pulse        (pulse),
    .btn_mode     (btn_mode),
    .btn_inc      (btn_inc),
    .btn_alarm    (btn_alarm),
    .left_hr      (left_hr),
    .right_hr     (right_hr),
    .left_min     (left_min),
    .right_min    (right_min),
    .left_sec     (left_sec),
    .right_sec    (right_sec),
    .sec_pulse    (sec_pulse),
    .sec_clr      (sec_clr),
    .min_inc      (min_inc),
    .hr_inc       (hr_inc),
    .al_left_hr   (al_left_hr),
    .al_right_hr  (al_right_hr),
    .al_left_min  (al_left_min),
    .al_right_min (al_right_min),
    .mode         (mode),
    .blink        (blink),
    .alarm_on     (alarm_on),
    .buzzer       (buzzer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_counts();
    cnt_sec_pulse = 0; cnt_sec_clr = 0; cnt_hr_inc = 0; cnt_min_inc = 0;
  endtask

  // Advance one cycle and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (sec_pulse) cnt_sec_pulse++;
    if (sec_clr)   cnt_sec_clr++;
    if (hr_inc)    cnt_hr_inc++;
    if (min_inc)   cnt_min_inc++;
  endtask

  task automatic set_time(input logic [7:0] hr, input logic [7:0] mn, input logic [7:0] sc);
    {left_hr, right_hr} = hr;
    {left_min, right_min} = mn;
    {left_sec, right_sec} = sc;
  endtask

  task automatic press(input logic a, input logic m, input logic i, input int hold);
    btn_alarm = a; btn_mode = m; btn_inc = i;
    repeat (hold) step();
    btn_alarm = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (3) step();
  endtask

  task automatic pulse_once();
    pulse = 1'b1;
    step();
    pulse = 1'b0;
    repeat (2) step();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if (mode !== 3'd0 || buzzer !== 1'b0 || alarm_on !== 1'b0 || blink !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: mode=%0d buzzer=%b alarm_on=%b blink=%b, want 0 0 0 0",
               mode, buzzer, alarm_on, blink);
    end
    checks++;
    if ({al_left_hr, al_right_hr, al_left_min, al_right_min} !== 16'h0700) begin
      failures++;
      $display("FAIL reset_alarm: got %h want 0700",
               {al_left_hr, al_right_hr, al_left_min, al_right_min});
    end
    checks++;
    if ({sec_clr, min_inc, hr_inc, sec_pulse} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_strobes: got %b want 0000", {sec_clr, min_inc, hr_inc, sec_pulse});
    end
    rst = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_run_pulses();
    clear_counts();
    repeat (5) pulse_once();
    press(1'b0, 1'b0, 1'b1, 2);
    checks++;
    if (cnt_sec_pulse !== 5) begin
      failures++;
      $display("FAIL run_sec_pulse: got %0d pulses want 5", cnt_sec_pulse);
    end
    checks++;
    if (cnt_sec_clr + cnt_hr_inc + cnt_min_inc !== 0 || buzzer !== 1'b0 || mode !== 3'd0) begin
      failures++;
      $display("FAIL run_quiet: strobes=%0d buzzer=%b mode=%0d want 0 0 0",
               cnt_sec_clr + cnt_hr_inc + cnt_min_inc, buzzer, mode);
    end
  endtask

  task automatic test_set_hr();
    clear_counts();
    press(1'b0, 1'b1, 1'b0, 40);
    checks++;
    if (mode !== 3'd1 || cnt_sec_clr !== 1) begin
      failures++;
      $display("FAIL set_hr_enter: mode=%0d sec_clr=%0d want 1 1", mode, cnt_sec_clr);
    end
    repeat (3) press(1'b0, 1'b0, 1'b1, 5);
    checks++;
    if (cnt_hr_inc !== 3 || cnt_min_inc !== 0) begin
      failures++;
      $display("FAIL set_hr_inc: hr_inc=%0d min_inc=%0d want 3 0", cnt_hr_inc, cnt_min_inc);
    end
    pulse_once();
    checks++;
    if (blink !== 1'b1) begin
      failures++;
      $display("FAIL blink_first: got %b want 1", blink);
    end
    pulse_once();
    checks++;
    if (blink !== 1'b0 || cnt_sec_pulse !== 0) begin
      failures++;
      $display("FAIL blink_second: blink=%b sec_pulse=%0d want 0 0", blink, cnt_sec_pulse);
    end
  endtask

  task automatic test_alarm_set();
    logic [7:0] got;
    press(1'b0, 1'b1, 1'b0, 2);
    clear_counts();
    press(1'b0, 1'b0, 1'b1, 2);
    checks++;
    if (mode !== 3'd2 || cnt_min_inc !== 1 || cnt_hr_inc !== 0) begin
      failures++;
      $display("FAIL set_min: mode=%0d min_inc=%0d hr_inc=%0d want 2 1 0",
               mode, cnt_min_inc, cnt_hr_inc);
    end
    press(1'b0, 1'b1, 1'b0, 2);
    repeat (3) press(1'b0, 1'b0, 1'b1, 2);
    got = {al_left_hr, al_right_hr};
    checks++;
    if (mode !== 3'd3 || got !== 8'h10) begin
      failures++;
      $display("FAIL al_hr_carry: mode=%0d hr=%h want 3 10", mode, got);
    end
    repeat (14) press(1'b0, 1'b0, 1'b1, 2);
    got = {al_left_hr, al_right_hr};
    checks++;
    if (got !== 8'h00) begin
      failures++;
      $display("FAIL al_hr_wrap: hr=%h want 00", got);
    end
    clear_counts();
    pulse_once();
    checks++;
    if (cnt_sec_pulse !== 1) begin
      failures++;
      $display("FAIL al_time_runs: sec_pulse=%0d want 1", cnt_sec_pulse);
    end
    press(1'b0, 1'b1, 1'b0, 2);
    repeat (10) press(1'b0, 1'b0, 1'b1, 2);
    got = {al_left_min, al_right_min};
    checks++;
    if (mode !== 3'd4 || got !== 8'h10) begin
      failures++;
      $display("FAIL al_min_carry: mode=%0d min=%h want 4 10", mode, got);
    end
    repeat (49) press(1'b0, 1'b0, 1'b1, 2);
    got = {al_left_min, al_right_min};
    checks++;
    if (got !== 8'h59) begin
      failures++;
      $display("FAIL al_min_max: min=%h want 59", got);
    end
    press(1'b0, 1'b0, 1'b1, 2);
    got = {al_left_min, al_right_min};
    checks++;
    if (got !== 8'h00) begin
      failures++;
      $display("FAIL al_min_wrap: min=%h want 00", got);
    end
    press(1'b0, 1'b1, 1'b0, 2);
    checks++;
    if (mode !== 3'd0) begin
      failures++;
      $display("FAIL back_to_run: mode=%0d want 0", mode);
    end
  endtask

  task automatic test_ring();
    apply_reset();
    set_time(8'h12, 8'h34, 8'h56);
    press(1'b1, 1'b0, 1'b0, 2);
    checks++;
    if (alarm_on !== 1'b1 || buzzer !== 1'b0) begin
      failures++;
      $display("FAIL alarm_arm: alarm_on=%b buzzer=%b want 1 0", alarm_on, buzzer);
    end
    set_time(8'h07, 8'h00, 8'h00);
    step();
    checks++;
    if (buzzer !== 1'b1) begin
      failures++;
      $display("FAIL ring_start: buzzer=%b want 1", buzzer);
    end
    repeat (2) pulse_once();
    checks++;
    if (buzzer !== 1'b1) begin
      failures++;
      $display("FAIL ring_hold: buzzer=%b after 2 pulses want 1", buzzer);
    end
    pulse_once();
    checks++;
    if (buzzer !== 1'b0) begin
      failures++;
      $display("FAIL ring_end: buzzer=%b after 3 pulses want 0", buzzer);
    end
    repeat (5) step();
    checks++;
    if (buzzer !== 1'b0) begin
      failures++;
      $display("FAIL ring_no_retrigger: buzzer=%b want 0", buzzer);
    end
  endtask

  task automatic test_silence();
    set_time(8'h07, 8'h00, 8'h01);
    step();
    set_time(8'h07, 8'h00, 8'h00);
    step();
    checks++;
    if (buzzer !== 1'b1) begin
      failures++;
      $display("FAIL ring_again: buzzer=%b want 1", buzzer);
    end
    press(1'b0, 1'b1, 1'b0, 2);
    checks++;
    if (buzzer !== 1'b0 || mode !== 3'd0) begin
      failures++;
      $display("FAIL silence_mode: buzzer=%b mode=%0d want 0 0", buzzer, mode);
    end
    repeat (5) step();
    checks++;
    if (buzzer !== 1'b0) begin
      failures++;
      $display("FAIL silence_same_sec: buzzer=%b want 0", buzzer);
    end
    set_time(8'h07, 8'h00, 8'h01);
    step();
    set_time(8'h07, 8'h00, 8'h00);
    step();
    press(1'b1, 1'b0, 1'b1, 2);
    checks++;
    if (buzzer !== 1'b0 || alarm_on !== 1'b1) begin
      failures++;
      $display("FAIL silence_consumes: buzzer=%b alarm_on=%b want 0 1", buzzer, alarm_on);
    end
    set_time(8'h12, 8'h34, 8'h56);
    press(1'b0, 1'b1, 1'b0, 2);
    clear_counts();
    press(1'b1, 1'b0, 1'b1, 2);
    checks++;
    if (alarm_on !== 1'b0 || cnt_hr_inc !== 0 || mode !== 3'd1) begin
      failures++;
      $display("FAIL prio_alarm_inc: alarm_on=%b hr_inc=%0d mode=%0d want 0 0 1",
               alarm_on, cnt_hr_inc, mode);
    end
    press(1'b0, 1'b1, 1'b1, 2);
    checks++;
    if (mode !== 3'd2 || cnt_hr_inc + cnt_min_inc !== 0) begin
      failures++;
      $display("FAIL prio_mode_inc: mode=%0d incs=%0d want 2 0", mode,
               cnt_hr_inc + cnt_min_inc);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    press(1'b1, 1'b0, 1'b0, 2);
    set_time(8'h07, 8'h00, 8'h00);
    step();
    checks++;
    if (buzzer !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_ring: buzzer=%b want 1", buzzer);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (buzzer !== 1'b0 || alarm_on !== 1'b0 || mode !== 3'd0) begin
      failures++;
      $display("FAIL reset_mid_ring: buzzer=%b alarm_on=%b mode=%0d want 0 0 0",
               buzzer, alarm_on, mode);
    end
    step();
    rst = 1'b0;
    repeat (2) step();
    set_time(8'h12, 8'h34, 8'h56);
    repeat (4) press(1'b0, 1'b1, 1'b0, 2);
    repeat (2) press(1'b0, 1'b0, 1'b1, 2);
    pulse_once();
    checks++;
    if (mode !== 3'd4 || {al_left_min, al_right_min} !== 8'h02 || blink !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_al_min: mode=%0d min=%h blink=%b want 4 02 1",
               mode, {al_left_min, al_right_min}, blink);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (mode !== 3'd0 || blink !== 1'b0 ||
        {al_left_hr, al_right_hr, al_left_min, al_right_min} !== 16'h0700) begin
      failures++;
      $display("FAIL reset_mid_set: mode=%0d blink=%b alarm=%h want 0 0 0700", mode, blink,
               {al_left_hr, al_right_hr, al_left_min, al_right_min});
    end
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; pulse = 1'b0;
    btn_mode = 1'b0; btn_inc = 1'b0; btn_alarm = 1'b0;
    set_time(8'h12, 8'h34, 8'h56);
    clear_counts();
    test_reset();
    test_run_pulses();
    test_set_hr();
    test_alarm_set();
    test_ring();
    test_silence();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
